// File: rtl/spawnout_drain.sv
// Drains valid spawn-out queue entries from the BRAM second port onto an AXI-Stream master.
// Each word costs one BRAM read; the valid byte is cleared only after the last word handshakes.
module spawnout_drain #(
  parameter int QUEUE_LEN  = 1024,
  parameter int QUEUE_BITS = $clog2(QUEUE_LEN),
  parameter int COPY_WORDS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [31:0] queue_addr,
  output logic        queue_en,
  output logic [7:0]  queue_we,
  output logic [63:0] queue_din,
  input  logic [63:0] queue_dout,
  output logic [63:0] outStream_TDATA,
  output logic        outStream_TVALID,
  input  logic        outStream_TREADY,
  output logic        outStream_TLAST,
  output logic [31:0] tasks_drained
);

  localparam int ENTRY_VALID_BYTE_OFFSET = 7;
  localparam int ENTRY_VALID_OFFSET      = 8 * ENTRY_VALID_BYTE_OFFSET + 7;
  localparam int NUM_ARGS_OFFSET         = 32;
  localparam int NUM_DEPS_OFFSET         = 40;
  localparam int NUM_COPS_OFFSET         = 48;
  localparam logic [7:0] VALID_MASK      = 8'(1) << ENTRY_VALID_BYTE_OFFSET;

  typedef enum logic [2:0] {
    IDLE, HDR_RD, HDR_CHK, SEND, WORD_RD, WORD_LATCH, CLEAR
  } state_t;

  state_t                state_q;
  logic [QUEUE_BITS-1:0] ridx_q;
  logic [QUEUE_BITS-1:0] rdidx_q;
  logic [QUEUE_BITS-1:0] addr_idx_q;
  logic [6:0]            len_q;
  logic [6:0]            words_left_q;
  logic [63:0]           data_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic                  en_q;
  logic [7:0]            we_q;
  logic [31:0]           drained_q;
  logic [6:0]            hdr_len_d;

  // Largest entry is 4 + 15 + 15 + 15*COPY_WORDS words, so 7 bits suffice for COPY_WORDS <= 6.
  assign hdr_len_d = 7'd4
                   + 7'(queue_dout[NUM_ARGS_OFFSET +: 4])
                   + 7'(queue_dout[NUM_DEPS_OFFSET +: 4])
                   + 7'(queue_dout[NUM_COPS_OFFSET +: 4]) * 7'(COPY_WORDS);

  assign queue_addr       = {{(29 - QUEUE_BITS){1'b0}}, addr_idx_q, 3'b000};
  assign queue_en         = en_q;
  assign queue_we         = we_q;
  assign queue_din        = 64'd0;
  assign outStream_TDATA  = data_q;
  assign outStream_TVALID = tvalid_q;
  assign outStream_TLAST  = tlast_q;
  assign tasks_drained    = drained_q;

  // Outputs are set on the transition into a state so they line up with that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ridx_q       <= '0;
      rdidx_q      <= '0;
      addr_idx_q   <= '0;
      len_q        <= '0;
      words_left_q <= '0;
      data_q       <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      en_q         <= 1'b0;
      we_q         <= '0;
      drained_q    <= '0;
    end else begin
      en_q <= 1'b0;
      we_q <= '0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q    <= HDR_RD;
            en_q       <= 1'b1;
            addr_idx_q <= ridx_q;
          end
        end
        HDR_RD: state_q <= HDR_CHK;
        HDR_CHK: begin
          if (!queue_dout[ENTRY_VALID_OFFSET]) begin
            state_q <= IDLE;
          end else begin
            data_q       <= queue_dout;
            len_q        <= hdr_len_d;
            words_left_q <= hdr_len_d - 7'd1;
            rdidx_q      <= ridx_q + QUEUE_BITS'(1);
            tvalid_q     <= 1'b1;
            tlast_q      <= 1'b0;
            state_q      <= SEND;
          end
        end
        SEND: begin
          if (outStream_TREADY) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            en_q     <= 1'b1;
            if (words_left_q == 7'd0) begin
              we_q       <= VALID_MASK;
              addr_idx_q <= ridx_q;
              state_q    <= CLEAR;
            end else begin
              addr_idx_q <= rdidx_q;
              state_q    <= WORD_RD;
            end
          end
        end
        WORD_RD: state_q <= WORD_LATCH;
        WORD_LATCH: begin
          data_q       <= queue_dout;
          rdidx_q      <= rdidx_q + QUEUE_BITS'(1);
          words_left_q <= words_left_q - 7'd1;
          tlast_q      <= (words_left_q == 7'd1);
          tvalid_q     <= 1'b1;
          state_q      <= SEND;
        end
        CLEAR: begin
          ridx_q    <= ridx_q + QUEUE_BITS'(len_q);
          drained_q <= drained_q + 32'd1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spawnout_drain.sv
// Directed bench for spawnout_drain: BRAM model, stream/BRAM-port monitor, hand-built entries.
module tb_spawnout_drain;
  localparam int QL = 1024;
  localparam int QB = 10;
  localparam int CW = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] queue_addr;
  logic        queue_en;
  logic [7:0]  queue_we;
  logic [63:0] queue_din;
  logic [63:0] queue_dout;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tlast;
  logic [31:0] tasks_drained;

  int n_chk = 0;
  int n_fail = 0;

  spawnout_drain #(.QUEUE_LEN(QL), .QUEUE_BITS(QB), .COPY_WORDS(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .queue_addr(queue_addr), .queue_en(queue_en), .queue_we(queue_we),
    .queue_din(queue_din), .queue_dout(queue_dout),
    .outStream_TDATA(tdata), .outStream_TVALID(tvalid),
    .outStream_TREADY(tready), .outStream_TLAST(tlast),
    .tasks_drained(tasks_drained)
  );

  always #5 clk = ~clk;

  logic [63:0]   mem [QL];
  logic          host_we = 1'b0;
  logic [QB-1:0] host_addr = '0;
  logic [63:0]   host_dat = '0;
  logic [QB-1:0] idx;
  assign idx = queue_addr[3 +: QB];

  always @(posedge clk) begin
    if (host_we) mem[host_addr] <= host_dat;
    if (queue_en) begin
      for (int b = 0; b < 8; b++)
        if (queue_we[b]) mem[idx][b*8 +: 8] <= queue_din[b*8 +: 8];
      queue_dout <= mem[idx];
    end
  end

  int          rd_q[$];
  int          wr_addr_q[$];
  logic [7:0]  wr_we_q[$];
  logic [63:0] wr_din_q[$];
  logic [63:0] beat_dat_q[$];
  logic        beat_last_q[$];

  // Sample just before each rising edge, where everything is settled.
  always @(negedge clk) begin
    #4;
    if (!rst) begin
      if (queue_en && queue_we == 8'h00) rd_q.push_back(int'(idx));
      if (queue_en && queue_we != 8'h00) begin
        wr_addr_q.push_back(int'(idx));
        wr_we_q.push_back(queue_we);
        wr_din_q.push_back(queue_din);
      end
      if (tvalid && tready) begin
        beat_dat_q.push_back(tdata);
        beat_last_q.push_back(tlast);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input int a, input int d, input int c, input logic [15:0] id);
    return {8'h80, 8'(c), 8'(d), 8'(a), 16'h0000, id};
  endfunction

  function automatic logic [63:0] exp_word(input logic [15:0] id, input int k,
                                           input int a, input int d, input int c);
    if (k == 0) return hdr(a, d, c, id);
    return {16'h0000, id, 16'h0000, 16'(k)};
  endfunction

  task automatic poke(input int a, input logic [63:0] v);
    host_addr = QB'(a % QL);
    host_dat  = v;
    host_we   = 1'b1;
    @(negedge clk);
    host_we   = 1'b0;
  endtask

  task automatic put_entry(input int base, input int a, input int d, input int c, input logic [15:0] id);
    int len;
    len = 4 + a + d + c * CW;
    for (int k = 0; k < len; k++) poke(base + k, exp_word(id, k, a, d, c));
  endtask

  task automatic clear_logs();
    rd_q.delete(); wr_addr_q.delete(); wr_we_q.delete(); wr_din_q.delete();
    beat_dat_q.delete(); beat_last_q.delete();
  endtask

  task automatic wait_drained(input int target, input int budget);
    int n = 0;
    while (tasks_drained != 32'(target) && n < budget) begin @(negedge clk); n++; end
    check("drained", 64'(tasks_drained), 64'(target));
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (beat_dat_q.size() < target && n < budget) begin @(negedge clk); n++; end
    check("beats_reached", 64'(beat_dat_q.size()), 64'(target));
  endtask

  task automatic wait_tvalid(input int budget);
    int n = 0;
    while (!tvalid && n < budget) begin @(negedge clk); n++; end
    check("tvalid_wait", 64'(tvalid), 64'd1);
  endtask

  task automatic check_entry(input string tag, input int base, input int a, input int d, input int c,
                             input logic [15:0] id, input int boff, input int roff);
    int len;
    len = 4 + a + d + c * CW;
    check({tag, "_nbeats"}, 64'(beat_dat_q.size() >= boff + len), 64'd1);
    for (int k = 0; k < len; k++) begin
      if (boff + k < beat_dat_q.size()) begin
        check($sformatf("%s_dat%0d", tag, k), beat_dat_q[boff + k], exp_word(id, k, a, d, c));
        check($sformatf("%s_last%0d", tag, k), 64'(beat_last_q[boff + k]), 64'(k == len - 1));
      end
      if (roff + k < rd_q.size())
        check($sformatf("%s_rd%0d", tag, k), 64'(rd_q[roff + k]), 64'((base + k) % QL));
      else
        check($sformatf("%s_rd%0d_missing", tag, k), 64'(rd_q.size()), 64'(roff + k + 1));
    end
  endtask

  logic [63:0] h;
  logic [63:0] held_dat;
  logic        held_last;
  int          nrd;
  int          pos;
  int          polls;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_en", 64'(queue_en), 64'd0);
    check("rst_we", 64'(queue_we), 64'd0);
    check("rst_drained", 64'(tasks_drained), 64'd0);

    // Reset while beat 2 is on the stream: entry must be re-streamed from its header.
    put_entry(0, 1, 0, 0, 16'h0601);
    poke(5, 64'd0);
    clear_logs();
    rst = 1'b0; enable = 1'b1;
    wait_beats(1, 50);
    tready = 1'b0;
    wait_tvalid(20);
    check("rst_beat2_dat", tdata, exp_word(16'h0601, 1, 1, 0, 0));
    #1 rst = 1'b1;
    #1 check("rst_async_tvalid", 64'(tvalid), 64'd0);
    check("rst_async_en", 64'(queue_en), 64'd0);
    @(negedge clk);
    check("rst_hdr_kept", 64'(mem[0][63]), 64'd1);
    check("rst_no_write", 64'(wr_addr_q.size()), 64'd0);
    check("rst_drained0", 64'(tasks_drained), 64'd0);
    clear_logs();
    rst = 1'b0; tready = 1'b1;
    wait_drained(1, 200);
    check_entry("restream", 0, 1, 0, 0, 16'h0601, 0, 0);

    // Basic entry at word 0, then invalid header at word 7 is polled repeatedly.
    enable = 1'b0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    put_entry(0, 2, 1, 0, 16'h0101);
    poke(7, 64'd0);
    clear_logs();
    enable = 1'b1;
    wait_drained(1, 200);
    repeat (25) @(negedge clk);
    check_entry("basic", 0, 2, 1, 0, 16'h0101, 0, 0);
    check("basic_nwr", 64'(wr_addr_q.size()), 64'd1);
    if (wr_addr_q.size() > 0) begin
      check("basic_wr_addr", 64'(wr_addr_q[0]), 64'd0);
      check("basic_wr_we", 64'(wr_we_q[0]), 64'h80);
      check("basic_wr_din", wr_din_q[0], 64'd0);
    end
    h = hdr(2, 1, 0, 16'h0101);
    h[63:56] = 8'h00;
    check("basic_hdr_cleared", mem[0], h);
    check("poll_no_beats", 64'(beat_dat_q.size()), 64'd7);
    polls = 0;
    for (int i = 7; i < rd_q.size(); i++) begin
      check($sformatf("poll_addr%0d", i), 64'(rd_q[i]), 64'd7);
      polls++;
    end
    check("poll_repeats", 64'(polls >= 4), 64'd1);

    // Walk the read index to 1021 with filler entries, then drain an entry across the wrap.
    enable = 1'b0;
    repeat (3) @(negedge clk);
    pos = 7;
    for (int e = 0; e < 12; e++) begin
      put_entry(pos, 15, 15, 15, 16'h0200 + 16'(e));
      pos += 79;
    end
    put_entry(pos, 14, 15, 11, 16'h02ff);
    put_entry(1021, 0, 0, 1, 16'h0301);
    poke(4, 64'd0);
    enable = 1'b1;
    wait_drained(14, 6000);
    clear_logs();
    wait_drained(15, 200);
    repeat (5) @(negedge clk);
    check_entry("wrap", 1021, 0, 0, 1, 16'h0301, 0, 0);
    if (wr_addr_q.size() > 0) check("wrap_wr_addr", 64'(wr_addr_q[0]), 64'd1021);
    else check("wrap_wr_missing", 64'(wr_addr_q.size()), 64'd1);
    if (rd_q.size() > 7) check("wrap_next_poll", 64'(rd_q[7]), 64'd4);
    else check("wrap_next_poll_missing", 64'(rd_q.size()), 64'd8);

    // Hold TREADY low for 10 cycles while beat 3 is presented.
    enable = 1'b0;
    repeat (3) @(negedge clk);
    put_entry(4, 1, 0, 0, 16'h0401);
    poke(9, 64'd0);
    clear_logs();
    enable = 1'b1;
    wait_beats(2, 100);
    tready = 1'b0;
    wait_tvalid(20);
    held_dat  = tdata;
    held_last = tlast;
    nrd = rd_q.size();
    check("stall_beat3", held_dat, exp_word(16'h0401, 2, 1, 0, 0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("stall_tvalid%0d", i), 64'(tvalid), 64'd1);
      check($sformatf("stall_tdata%0d", i), tdata, held_dat);
      check($sformatf("stall_tlast%0d", i), 64'(tlast), 64'(held_last));
    end
    check("stall_no_reads", 64'(rd_q.size()), 64'(nrd));
    tready = 1'b1;
    wait_drained(16, 200);
    check_entry("stall", 4, 1, 0, 0, 16'h0401, 0, 0);

    // Two minimal entries back to back.
    enable = 1'b0;
    repeat (3) @(negedge clk);
    put_entry(9, 0, 0, 0, 16'h0501);
    put_entry(13, 0, 0, 0, 16'h0502);
    poke(17, 64'd0);
    clear_logs();
    enable = 1'b1;
    wait_drained(18, 300);
    repeat (5) @(negedge clk);
    check_entry("min1", 9, 0, 0, 0, 16'h0501, 0, 0);
    check_entry("min2", 13, 0, 0, 0, 16'h0502, 4, 4);
    check("min_nwr", 64'(wr_addr_q.size()), 64'd2);
    if (wr_addr_q.size() > 1) begin
      check("min_wr0", 64'(wr_addr_q[0]), 64'd9);
      check("min_wr1", 64'(wr_addr_q[1]), 64'd13);
    end
    if (rd_q.size() > 8) check("min_next_poll", 64'(rd_q[8]), 64'd17);
    else check("min_next_poll_missing", 64'(rd_q.size()), 64'd9);

    enable = 1'b0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
